alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 4 to 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an operation is presented on a, b and sel.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  N  operand A.
REQ-007 b  input  N  operand B.
REQ-008 sel  input  4  opcode.
REQ-009 out_valid  output  1  one-cycle pulse; s, hi and the flags hold a new result.
REQ-010 s  output  N  result, low word.
REQ-011 hi  output  N  MUL high word; 0 for all other opcodes.
REQ-012 co  output  1  carry/borrow flag.
REQ-013 z  output  1  zero flag, (s == 0).
REQ-014 neg  output  1  sign flag, s[N-1].
REQ-015 ov  output  1  signed overflow flag.

Function
REQ-016 The block SHALL accept an operation on a rising edge where in_valid and in_ready are both 1; a, b and sel are sampled on that edge only.
REQ-017 The state machine SHALL have two states: IDLE (in_ready=1) and MUL (in_ready=0).
REQ-018 State transitions SHALL be: IDLE->MUL on acceptance with sel=MUL; MUL->IDLE after N iterations; all other cases hold state.
REQ-019 Non-MUL ops SHALL complete in 1 cycle: s, hi, flags registered and out_valid=1 in the cycle after acceptance; back-to-back acceptance every cycle is allowed.
REQ-020 Opcodes, with carry-outs computed on N+1 bits and the result and co written as one (N+1)-bit value where arithmetic:
- 0 ADD: a+b.
- 1 SUB: a-b; co=1 on borrow.
- 2 INR: a+1.
- 3 DCR: a-1.
- 4 AND: a&b, co=0.
- 5 OR: a|b, co=0.
- 6 XOR: a^b, co=0.
- 7 CMP: s=~b, co=0.
REQ-021 Further opcodes:
- 8 ADC: a+b+cf.
- 9 SBB: a-b-cf.
- A SHL: s=a<<1, co=a[N-1].
- B SHR: s=a>>1 (logical), co=a[0].
- C ROL: co=a[N-1].
- D ROR: co=a[0].
- E MUL.
- F PASS: s=a, co=0.
REQ-022 cf SHALL be the registered co of the most recent completed operation; cf is 0 after reset.
REQ-023 ov SHALL be the signed two's-complement overflow for ADD, SUB, INR, DCR, ADC and SBB, and 0 for all other opcodes.
REQ-024 MUL SHALL be unsigned shift-add, one partial-product step per cycle for N cycles; out_valid SHALL assert N+1 cycles after the accepting edge.
- {hi,s} = a*b.
- co = |hi.
- ov = 0.
REQ-025 in_ready SHALL be 0 for exactly N cycles after a MUL is accepted; it returns to 1 in the same cycle out_valid pulses for that MUL.
REQ-026 in_valid while in_ready=0 SHALL be ignored: no acceptance and no state change.
REQ-027 Between completions, s, hi and all flags SHALL hold their last values.

Reset
REQ-028 While rst=1: in_ready=1, out_valid=0, s=0, hi=0, co=0, z=0, neg=0, ov=0, cf=0, state=IDLE.
REQ-029 rst SHALL take priority over acceptance and iteration; rst during MUL aborts the operation with no out_valid pulse.

Verification (N=8)
REQ-030 ADD FF+01 -> next cycle: out_valid=1, s=00, co=1, z=1, ov=0.
REQ-031 ADD 7F+01 -> s=80, neg=1, ov=1, co=0; then SUB 03-05 -> s=FE, co=1.
REQ-032 SUB 00-01 (cf=1), then SBB 05-02 -> SBB result s=02, co=0.
REQ-033 MUL FF*FF -> in_ready=0 for 8 cycles, out_valid on cycle 9 with s=01, hi=FE, co=1; in_valid held during the busy period is not accepted.
REQ-034 rst pulsed in the 4th MUL cycle -> no out_valid, all outputs 0, in_ready=1 in the next cycle; a following ADD 02+03 -> s=05.
REQ-035 ROL 81 -> s=03, co=1; ROR 01 -> s=80, co=1; CMP b=0F -> s=F0, co=0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ops plus an N-cycle
// unsigned shift-add multiplier that holds off new work while it iterates.
module alu_seq #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic         out_valid,
  output logic [N-1:0] s,
  output logic [N-1:0] hi,
  output logic         co,
  output logic         z,
  output logic         neg,
  output logic         ov
);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpInr  = 4'h2;
  localparam logic [3:0] OpDcr  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpCmp  = 4'h7;
  localparam logic [3:0] OpAdc  = 4'h8;
  localparam logic [3:0] OpSbb  = 4'h9;
  localparam logic [3:0] OpShl  = 4'hA;
  localparam logic [3:0] OpShr  = 4'hB;
  localparam logic [3:0] OpRol  = 4'hC;
  localparam logic [3:0] OpRor  = 4'hD;
  localparam logic [3:0] OpMul  = 4'hE;
  localparam logic [3:0] OpPass = 4'hF;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e         r_state, w_state_next;
  logic [N-1:0]   r_mcand, r_mpl;
  logic [2*N-1:0] r_acc, w_acc_next;
  logic [N:0]     w_sum;
  logic [5:0]     r_cnt;
  logic           w_accept, w_last;
  logic [N:0]     w_res;
  logic           w_ov;

  logic [N-1:0]   r_s, r_hi;
  logic           r_co, r_z, r_neg, r_ov, r_out_valid;

  assign in_ready  = rst | (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign hi        = r_hi;
  assign co        = r_co;
  assign z         = r_z;
  assign neg       = r_neg;
  assign ov        = r_ov;

  assign w_accept = in_valid && (r_state == StIdle);
  assign w_last   = (r_state == StMul) && (r_cnt == 6'(N - 1));

  // Add the multiplicand into the high half, then shift the whole product right.
  assign w_sum      = {1'b0, r_acc[2*N-1:N]} + (r_mpl[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[N-1:1]};

  // Single-cycle datapath; co lives in w_res[N], r_co doubles as the carry-in cf.
  always_comb begin
    w_res = '0;
    w_ov  = 1'b0;
    case (sel)
      OpAdd: begin
        w_res = {1'b0, a} + {1'b0, b};
        w_ov  = (a[N-1] == b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      OpSub: begin
        w_res = {1'b0, a} - {1'b0, b};
        w_ov  = (a[N-1] != b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      OpInr: begin
        w_res = {1'b0, a} + (N+1)'(1);
        w_ov  = !a[N-1] && w_res[N-1];
      end
      OpDcr: begin
        w_res = {1'b0, a} - (N+1)'(1);
        w_ov  = a[N-1] && !w_res[N-1];
      end
      OpAnd:  w_res = {1'b0, a & b};
      OpOr:   w_res = {1'b0, a | b};
      OpXor:  w_res = {1'b0, a ^ b};
      OpCmp:  w_res = {1'b0, ~b};
      OpAdc: begin
        w_res = {1'b0, a} + {1'b0, b} + (N+1)'(r_co);
        w_ov  = (a[N-1] == b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      OpSbb: begin
        w_res = {1'b0, a} - {1'b0, b} - (N+1)'(r_co);
        w_ov  = (a[N-1] != b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      OpShl:  w_res = {a[N-1], a[N-2:0], 1'b0};
      OpShr:  w_res = {a[0], 1'b0, a[N-1:1]};
      OpRol:  w_res = {a[N-1], a[N-2:0], a[N-1]};
      OpRor:  w_res = {a[0], a[0], a[N-1:1]};
      OpPass: w_res = {1'b0, a};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept && (sel == OpMul)) w_state_next = StMul;
      StMul:  if (w_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mcand     <= '0;
      r_mpl       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_s         <= '0;
      r_hi        <= '0;
      r_co        <= 1'b0;
      r_z         <= 1'b0;
      r_neg       <= 1'b0;
      r_ov        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= 1'b0;
      if (w_accept) begin
        if (sel == OpMul) begin
          r_mcand <= a;
          r_mpl   <= b;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_s         <= w_res[N-1:0];
          r_hi        <= '0;
          r_co        <= w_res[N];
          r_z         <= (w_res[N-1:0] == '0);
          r_neg       <= w_res[N-1];
          r_ov        <= w_ov;
          r_out_valid <= 1'b1;
        end
      end else if (r_state == StMul) begin
        r_acc <= w_acc_next;
        r_mpl <= r_mpl >> 1;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) begin
          r_s         <= w_acc_next[N-1:0];
          r_hi        <= w_acc_next[2*N-1:N];
          r_co        <= |w_acc_next[2*N-1:N];
          r_z         <= (w_acc_next[N-1:0] == '0);
          r_neg       <= w_acc_next[N-1];
          r_ov        <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at N=8: ALU vector table, MUL timing,
// busy-period input rejection and reset abort of a multiply.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic       out_valid;
  logic [7:0] s, hi;
  logic       co, z, neg, ov;

  int n_total = 0;
  int n_pass  = 0;

  alu_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .s         (s),
    .hi        (hi),
    .co        (co),
    .z         (z),
    .neg       (neg),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  // {sel, a, b, expected s, expected {co, z, neg, ov}}; rows run back to back so cf chains.
  localparam logic [31:0] AluVec [23] = '{
    32'h0_FF_01_00_C, 32'h0_7F_01_80_3, 32'h1_03_05_FE_A, 32'h1_00_01_FF_A,
    32'h9_05_02_02_0, 32'h0_FF_01_00_C, 32'h8_10_20_31_0, 32'h2_7F_00_80_3,
    32'h3_00_00_FF_A, 32'h3_80_00_7F_1, 32'h4_F0_3C_30_0, 32'h5_F0_3C_FC_2,
    32'h6_F0_3C_CC_2, 32'h7_00_0F_F0_2, 32'hA_81_00_02_8, 32'hB_81_00_40_8,
    32'hC_81_00_03_8, 32'hD_01_00_80_A, 32'hF_5A_00_5A_0, 32'h0_80_80_00_D,
    32'h8_7F_00_80_3, 32'h1_00_01_FF_A, 32'h9_80_00_7F_1
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0;
    step(); step();
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    n_total++;
    if (got !== 22'h200000) $display("FAIL reset_state: got %h expected %h", got, 22'h200000);
    else n_pass++;
    in_valid = 1'b1; sel = 4'h0; a = 8'hFF; b = 8'h01;
    step();
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    n_total++;
    if (got !== 22'h200000) $display("FAIL reset_blocks_accept: got %h expected %h", got, 22'h200000);
    else n_pass++;
    in_valid = 1'b0; rst = 1'b0;
    step();
  endtask

  // Held in_valid with a new op every cycle: each row is also a back-to-back acceptance.
  task automatic test_alu_table();
    logic [20:0] got, exp;
    for (int i = 0; i < 23; i++) begin
      logic [31:0] row;
      row = AluVec[i];
      sel = row[31:28]; a = row[27:20]; b = row[19:12]; in_valid = 1'b1;
      step();
      got = {out_valid, hi, s, co, z, neg, ov};
      exp = {1'b1, 8'h00, row[11:4], row[3:0]};
      n_total++;
      if (got !== exp) $display("FAIL alu_row%0d sel=%h: got %h expected %h", i, row[31:28], got, exp);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [20:0] got;
    sel = 4'h0; a = 8'h11; b = 8'h22; in_valid = 1'b0;
    step(); step();
    // Last table row left s=7F, ov=1; nothing accepted since.
    got = {out_valid, hi, s, co, z, neg, ov};
    n_total++;
    if (got !== {1'b0, 8'h00, 8'h7F, 4'b0001})
      $display("FAIL hold_outputs: got %h expected %h", got, {1'b0, 8'h00, 8'h7F, 4'b0001});
    else n_pass++;
  endtask

  task automatic test_mul(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ehi,
                          input logic [7:0] es, input logic [3:0] eflags);
    logic [21:0] got, exp;
    int          busy_bad;
    sel = 4'hE; a = ta; b = tb_; in_valid = 1'b1;
    step();
    // Keep offering an ADD through the busy window; it must be ignored.
    sel = 4'h0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    busy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      step();
    end
    n_total++;
    if (busy_bad != 0) $display("FAIL mul_busy_%h_%h: got %0d bad cycles expected 0", ta, tb_, busy_bad);
    else n_pass++;
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    exp = {2'b11, ehi, es, eflags};
    in_valid = 1'b0;
    n_total++;
    if (got !== exp) $display("FAIL mul_result_%h_%h: got %h expected %h", ta, tb_, got, exp);
    else n_pass++;
    step();
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    exp = {2'b10, ehi, es, eflags};
    n_total++;
    if (got !== exp) $display("FAIL mul_after_%h_%h: got %h expected %h", ta, tb_, got, exp);
    else n_pass++;
  endtask

  task automatic test_mul_reset();
    logic [21:0] got;
    int          pulses;
    sel = 4'hF; a = 8'h5A; b = 8'h00; in_valid = 1'b1;
    step();
    sel = 4'hE; a = 8'hFF; b = 8'hFF;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    n_total++;
    if (got !== 22'h200000) $display("FAIL mul_reset_clear: got %h expected %h", got, 22'h200000);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) pulses++;
      step();
    end
    n_total++;
    if (pulses != 0) $display("FAIL mul_reset_no_valid: got %0d pulses expected 0", pulses);
    else n_pass++;
    sel = 4'h0; a = 8'h02; b = 8'h03; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    got = {in_ready, out_valid, hi, s, co, z, neg, ov};
    n_total++;
    if (got !== {2'b11, 8'h00, 8'h05, 4'b0000})
      $display("FAIL add_after_reset: got %h expected %h", got, {2'b11, 8'h00, 8'h05, 4'b0000});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_table();
    test_hold();
    test_mul(8'hFF, 8'hFF, 8'hFE, 8'h01, 4'b1000);
    test_mul(8'h0D, 8'h0B, 8'h00, 8'h8F, 4'b0010);
    test_mul(8'h10, 8'h10, 8'h01, 8'h00, 4'b1100);
    test_mul_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
